// File: rtl/nonce_report_arbiter.sv
// Round-robin arbiter that collects per-core golden nonces and feeds them one word at a time to serial_transmit.
// Optional build macro NONCE_FLUSH_ON_WORK_EN: a new_work pulse discards all pending nonces.
module nonce_report_arbiter #(
    parameter int unsigned NUM_CORES    = 4,
    parameter int unsigned IDX_W        = 2,
    parameter int unsigned BUSY_TIMEOUT = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CORES-1:0]    nonce_valid,
    input  logic [32*NUM_CORES-1:0] nonce_in,
    input  logic                    new_work,
    output logic [31:0]             tx_word,
    output logic                    tx_send,
    input  logic                    tx_busy,
    output logic [NUM_CORES-1:0]    pending,
    output logic [7:0]              drop_count
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t                        state_q, state_d;
    logic [IDX_W-1:0]              rr_q, rr_d;
    logic [IDX_W-1:0]              gnt_q, gnt_d;
    logic [7:0]                    cnt_q, cnt_d;
    logic [NUM_CORES-1:0]          pending_q, pending_d;
    logic [NUM_CORES-1:0][31:0]    slot_q, slot_d;
    logic [31:0]                   tx_word_q, tx_word_d;
    logic                          tx_send_q, tx_send_d;
    logic [7:0]                    drop_q, drop_d;

    logic                          found;
    logic [IDX_W-1:0]              sel;
    logic [31:0]                   sel_word;
    logic [NUM_CORES-1:0]          clr;
    logic                          flush;
    logic                          dropped;

`ifdef NONCE_FLUSH_ON_WORK_EN
    assign flush = new_work;
`else
    logic unused_new_work;
    assign unused_new_work = new_work;
    assign flush = 1'b0;
`endif

    // Two passes: first set index at or above rr_q, otherwise the lowest set index (wrap).
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        sel_word = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (!found && pending_q[i] && (i >= 32'(rr_q))) begin
                found = 1'b1;
                sel   = IDX_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (!found && pending_q[i]) begin
                found = 1'b1;
                sel   = IDX_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (32'(sel) == i) begin
                sel_word = slot_q[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        tx_word_d = tx_word_q;
        tx_send_d = 1'b0;
        clr       = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d     = sel;
                    tx_word_d = sel_word;
                    state_d   = SEND;
                    for (int unsigned i = 0; i < NUM_CORES; i++) begin
                        clr[i] = (32'(sel) == i);
                    end
                end
            end
            SEND: begin
                tx_send_d = 1'b1;
                cnt_d     = '0;
                if (!tx_busy) begin
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                    cnt_d   = '0;
                end else if (cnt_q == 8'(BUSY_TIMEOUT - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                    rr_d    = (32'(gnt_q) == NUM_CORES - 1) ? '0 : gnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A capture into a slot being granted (or flushed) this cycle wins over the clear.
    always_comb begin
        slot_d    = slot_q;
        pending_d = flush ? '0 : (pending_q & ~clr);
        dropped   = 1'b0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (nonce_valid[i]) begin
                if (!pending_q[i] || clr[i] || flush) begin
                    slot_d[i]    = nonce_in[32*i +: 32];
                    pending_d[i] = 1'b1;
                end else begin
                    dropped = 1'b1;
                end
            end
        end
        drop_d = (dropped && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            gnt_q     <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
            slot_q    <= '0;
            tx_word_q <= '0;
            tx_send_q <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            slot_q    <= slot_d;
            tx_word_q <= tx_word_d;
            tx_send_q <= tx_send_d;
            drop_q    <= drop_d;
        end
    end

    assign tx_word    = tx_word_q;
    assign tx_send    = tx_send_q;
    assign pending    = pending_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_nonce_report_arbiter.sv
// Scoreboard bench for nonce_report_arbiter with a simple serial_transmit busy model.
module tb_nonce_report_arbiter;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   nonce_valid = '0;
    logic [127:0] nonce_in = '0;
    logic         new_work = 1'b0;
    logic [31:0]  tx_word;
    logic         tx_send;
    logic         tx_busy;
    logic [3:0]   pending;
    logic [7:0]   drop_count;

    logic         force_busy = 1'b0;
    logic         model_en = 1'b1;
    logic         model_busy = 1'b0;
    int           busy_cnt = 0;

    int           n_tests = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           send_count = 0;
    int           last_send_cyc = 0;
    logic         prev_send = 1'b0;
    logic [31:0]  exp_q[$];
    logic [31:0]  exp_w;
    int           base, t0, s1;

    assign tx_busy = force_busy | model_busy;

    nonce_report_arbiter #(
        .NUM_CORES   (4),
        .IDX_W       (2),
        .BUSY_TIMEOUT(7)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .nonce_valid(nonce_valid),
        .nonce_in   (nonce_in),
        .new_work   (new_work),
        .tx_word    (tx_word),
        .tx_send    (tx_send),
        .tx_busy    (tx_busy),
        .pending    (pending),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter: busy rises one cycle after a send and holds for 40 cycles.
    always @(negedge clk) begin
        if (model_busy) begin
            busy_cnt = busy_cnt - 1;
            if (busy_cnt == 0) model_busy = 1'b0;
        end else if (model_en && !force_busy && tx_send) begin
            model_busy = 1'b1;
            busy_cnt   = 40;
        end
    end

    // Monitor: every rising edge of tx_send is one reported word.
    always @(negedge clk) begin
        if (tx_send && !prev_send) begin
            send_count    = send_count + 1;
            last_send_cyc = cyc;
            n_tests       = n_tests + 1;
            if (exp_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL unexpected_send: got tx_word=%h, no word expected", tx_word);
            end else begin
                exp_w = exp_q.pop_front();
                if (tx_word !== exp_w) begin
                    n_fail = n_fail + 1;
                    $display("FAIL send_word: got %h, want %h", tx_word, exp_w);
                end
            end
        end
        prev_send = tx_send;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic pulse(input int core, input logic [31:0] w);
        nonce_valid = '0;
        nonce_valid[core] = 1'b1;
        nonce_in[32*core +: 32] = w;
        tick(1);
        nonce_valid = '0;
    endtask

    task automatic wait_sends(input int target, input string name);
        int k;
        k = 0;
        while (send_count < target && k < 400) begin
            tick(1);
            k++;
        end
        check(name, send_count, target);
    endtask

    task automatic wait_model_idle();
        int k;
        k = 0;
        while (model_busy && k < 100) begin
            tick(1);
            k++;
        end
        check("model_idle", {31'd0, model_busy}, 32'd0);
        tick(3);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        nonce_valid = '0;
        new_work    = 1'b0;
        force_busy  = 1'b0;
        model_en    = 1'b1;
        tick(2);
        reset = 1'b0;
        wait_model_idle();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        check("rst_tx_send", {31'd0, tx_send}, 32'd0);
        check("rst_tx_word", tx_word, 32'd0);
        check("rst_pending", {28'd0, pending}, 32'd0);
        check("rst_drop", {24'd0, drop_count}, 32'd0);
        reset = 1'b0;
        tick(1);

        // Single nonce and latency
        base = send_count;
        t0 = cyc;
        exp_q.push_back(32'hDEADBEEF);
        pulse(1, 32'hDEADBEEF);
        wait_sends(base + 1, "single_send");
        check("single_latency", last_send_cyc - t0, 32'd3);
        wait_model_idle();
        tick(10);
        check("single_count", send_count, base + 1);
        check("single_pending", {28'd0, pending}, 32'd0);
        check("tx_word_hold", tx_word, 32'hDEADBEEF);

        // Round-robin from rr_ptr 0, then wrap back to 0
        do_reset();
        base = send_count;
        exp_q.push_back(32'h11111111);
        exp_q.push_back(32'h22222222);
        exp_q.push_back(32'h33333333);
        nonce_in[31:0]   = 32'h11111111;
        nonce_in[95:64]  = 32'h22222222;
        nonce_in[127:96] = 32'h33333333;
        nonce_valid = 4'b1101;
        tick(1);
        nonce_valid = '0;
        wait_sends(base + 3, "rr_three");
        wait_model_idle();
        exp_q.push_back(32'hAAAA0000);
        exp_q.push_back(32'hBBBB0003);
        nonce_in[31:0]   = 32'hAAAA0000;
        nonce_in[127:96] = 32'hBBBB0003;
        nonce_valid = 4'b1001;
        tick(1);
        nonce_valid = '0;
        wait_sends(base + 5, "rr_pair");
        wait_model_idle();

        // Overflow and saturation with the transmitter held busy
        do_reset();
        base = send_count;
        force_busy = 1'b1;
        exp_q.push_back(32'h0000C0DE);
        pulse(2, 32'h0000C0DE);
        tick(3);
        pulse(2, 32'h00002222);
        pulse(2, 32'h0000DEAD);
        tick(1);
        check("drop_one", {24'd0, drop_count}, 32'd1);
        pulse(0, 32'h00000A00);
        pulse(1, 32'h00000B01);
        nonce_valid = 4'b0111;
        tick(1);
        nonce_valid = '0;
        tick(1);
        check("drop_simultaneous", {24'd0, drop_count}, 32'd2);
        check("ovf_pending", {28'd0, pending}, 32'h7);
        for (int i = 0; i < 300; i++) begin
            nonce_valid = 4'b0100;
            nonce_in[95:64] = 32'hF0000000 + 32'(i);
            tick(1);
        end
        nonce_valid = '0;
        tick(1);
        check("drop_saturate", {24'd0, drop_count}, 32'd255);
        exp_q.push_back(32'h00000A00);
        exp_q.push_back(32'h00000B01);
        exp_q.push_back(32'h00002222);
        force_busy = 1'b0;
        wait_sends(base + 4, "ovf_sends");
        wait_model_idle();
        check("drop_stays", {24'd0, drop_count}, 32'd255);

        // Capture in the grant cycle of the same core
        do_reset();
        base = send_count;
        exp_q.push_back(32'h01010101);
        exp_q.push_back(32'h02020202);
        nonce_valid = 4'b0010;
        nonce_in[63:32] = 32'h01010101;
        tick(1);
        nonce_in[63:32] = 32'h02020202;
        tick(1);
        nonce_valid = '0;
        wait_sends(base + 2, "collision_sends");
        wait_model_idle();
        check("collision_pending", {28'd0, pending}, 32'd0);
        check("collision_drop", {24'd0, drop_count}, 32'd0);

        // Busy never rises: each word times out after BUSY_TIMEOUT cycles
        do_reset();
        model_en = 1'b0;
        base = send_count;
        exp_q.push_back(32'h7A7A0000);
        exp_q.push_back(32'h7A7A0001);
        nonce_in[31:0]  = 32'h7A7A0000;
        nonce_in[63:32] = 32'h7A7A0001;
        nonce_valid = 4'b0011;
        tick(1);
        nonce_valid = '0;
        wait_sends(base + 1, "timeout_first");
        s1 = last_send_cyc;
        wait_sends(base + 2, "timeout_second");
        // 7 cycles in WAIT_BUSY, then grant, then send
        check("timeout_gap", last_send_cyc - s1, 32'd9);
        tick(20);
        check("timeout_no_resend", send_count, base + 2);
        check("timeout_drop", {24'd0, drop_count}, 32'd0);
        model_en = 1'b1;

        // Reset while waiting for the transmitter to finish
        do_reset();
        base = send_count;
        exp_q.push_back(32'h0BADF00D);
        pulse(0, 32'h0BADF00D);
        wait_sends(base + 1, "rstwd_send");
        tick(5);
        pulse(1, 32'h55555555);
        check("rstwd_pending_before", {28'd0, pending}, 32'h2);
        reset = 1'b1;
        tick(1);
        check("rstwd_tx_send", {31'd0, tx_send}, 32'd0);
        check("rstwd_tx_word", tx_word, 32'd0);
        check("rstwd_pending", {28'd0, pending}, 32'd0);
        check("rstwd_drop", {24'd0, drop_count}, 32'd0);
        reset = 1'b0;
        wait_model_idle();
        tick(20);
        check("rstwd_no_send", send_count, base + 1);

        // new_work with three slots pending behind a held transfer
        do_reset();
        base = send_count;
        force_busy = 1'b1;
        exp_q.push_back(32'h30000003);
        pulse(3, 32'h30000003);
        tick(3);
        nonce_in[63:32] = 32'h10000001;
        nonce_in[95:64] = 32'h20000002;
        nonce_valid = 4'b0110;
        tick(1);
        nonce_valid = '0;
        check("nw_pending_before", {28'd0, pending}, 32'h6);
`ifdef NONCE_FLUSH_ON_WORK_EN
        new_work = 1'b1;
        nonce_valid = 4'b0001;
        nonce_in[31:0] = 32'h0E0E0E0E;
        tick(1);
        new_work = 1'b0;
        nonce_valid = '0;
        check("flush_pending", {28'd0, pending}, 32'h1);
        exp_q.push_back(32'h0E0E0E0E);
        force_busy = 1'b0;
        wait_sends(base + 2, "flush_sends");
`else
        new_work = 1'b1;
        tick(1);
        new_work = 1'b0;
        check("nw_pending_kept", {28'd0, pending}, 32'h6);
        exp_q.push_back(32'h10000001);
        exp_q.push_back(32'h20000002);
        force_busy = 1'b0;
        wait_sends(base + 3, "nw_sends");
`endif
        wait_model_idle();
        tick(60);
`ifdef NONCE_FLUSH_ON_WORK_EN
        check("flush_total", send_count, base + 2);
`else
        check("nw_total", send_count, base + 3);
`endif
        check("nw_drop", {24'd0, drop_count}, 32'd0);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
